// File: rtl/instruction_encoder_if.sv
// Loader/fetch-facing bus of the instruction encoder: descriptor handshake,
// load control/status and the fetch port.
interface instruction_encoder_if #(parameter int ADDR_W = 6);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_op;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [12:0]       in_imm;
  logic              seal;
  logic              clear;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              err;
  logic [7:0]        err_cnt;
  logic              sealed;
  logic [63:0]       fetch_addr;
  logic [31:0]       fetch_inst;
  logic              fetch_valid;

  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, seal, clear, fetch_addr,
    input  in_ready, count, full, err, err_cnt, sealed, fetch_inst, fetch_valid
  );

  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, seal, clear, fetch_addr,
    output in_ready, count, full, err, err_cnt, sealed, fetch_inst, fetch_valid
  );
endinterface

// File: rtl/instruction_encoder.sv
// Encodes add/sub/and/or/ld/sd/beq descriptors into RV64 words, buffers them and
// serves them to fetch once sealed. Optional: ENC_X0_CHECK_EN rejects rd==x0 writers.
module instruction_encoder #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input logic                   clk,
  input logic                   rst_n,
  instruction_encoder_if.slave  enc
);
  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic [1:0] {S_LOAD, S_DRAIN, S_RUN} state_e;

  typedef struct packed {
    logic [2:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [12:0] imm;
  } desc_t;

  state_e            state_q;
  desc_t             stg_q;
  logic              stg_vld_q;
  logic [ADDR_W:0]   count_q;
  logic              err_q;
  logic [7:0]        err_cnt_q;
  logic              sealed_q;
  logic [31:0]       fetch_inst_q;
  logic              fetch_valid_q;
  logic [31:0]       mem [DEPTH];

  logic [ADDR_W+1:0] occ;
  logic              ready;
  logic              accept;
  logic              legal;
  logic [31:0]       word;
  logic              wr;
  logic              in_range;
  logic [ADDR_W-1:0] slot;

  // Occupancy includes the stage register so a full buffer never over-accepts.
  assign occ    = {1'b0, count_q} + (ADDR_W+2)'(stg_vld_q);
  assign ready  = (state_q == S_LOAD) && (occ < (ADDR_W+2)'(DEPTH));
  assign accept = enc.in_valid && ready;

  always_comb begin
    legal = 1'b1;
    word  = NOP;
    case (stg_q.op)
      3'd0: word = {7'b0000000, stg_q.rs2, stg_q.rs1, 3'b000, stg_q.rd, 7'b0110011};
      3'd1: word = {7'b0100000, stg_q.rs2, stg_q.rs1, 3'b000, stg_q.rd, 7'b0110011};
      3'd2: word = {7'b0000000, stg_q.rs2, stg_q.rs1, 3'b111, stg_q.rd, 7'b0110011};
      3'd3: word = {7'b0000000, stg_q.rs2, stg_q.rs1, 3'b110, stg_q.rd, 7'b0110011};
      3'd4: begin
        word  = {stg_q.imm[11:0], stg_q.rs1, 3'b011, stg_q.rd, 7'b0000011};
        legal = (stg_q.imm[12] == stg_q.imm[11]);
      end
      3'd5: begin
        word  = {stg_q.imm[11:5], stg_q.rs2, stg_q.rs1, 3'b011, stg_q.imm[4:0], 7'b0100011};
        legal = (stg_q.imm[12] == stg_q.imm[11]);
      end
      3'd6: begin
        word  = {stg_q.imm[12], stg_q.imm[10:5], stg_q.rs2, stg_q.rs1, 3'b000,
                 stg_q.imm[4:1], stg_q.imm[11], 7'b1100011};
        legal = ~stg_q.imm[0];
      end
      default: legal = 1'b0;
    endcase
`ifdef ENC_X0_CHECK_EN
    if (stg_q.op <= 3'd4 && stg_q.rd == 5'd0) legal = 1'b0;
`else
`endif
  end

  assign wr       = stg_vld_q && legal;
  assign slot     = enc.fetch_addr[ADDR_W+1:2];
  assign in_range = enc.fetch_addr < {{(64-ADDR_W-3){1'b0}}, count_q, 2'b00};

  // Buffer contents survive reset; only count decides what is visible.
  always_ff @(posedge clk) begin
    if (wr) mem[count_q[ADDR_W-1:0]] <= word;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_LOAD;
      stg_q         <= '0;
      stg_vld_q     <= 1'b0;
      count_q       <= '0;
      err_q         <= 1'b0;
      err_cnt_q     <= '0;
      sealed_q      <= 1'b0;
      fetch_inst_q  <= NOP;
      fetch_valid_q <= 1'b0;
    end else begin
      stg_vld_q <= accept;
      if (accept) stg_q <= '{op: enc.in_op, rd: enc.in_rd, rs1: enc.in_rs1,
                             rs2: enc.in_rs2, imm: enc.in_imm};
      err_q <= stg_vld_q && !legal;
      if (stg_vld_q && !legal && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
      if (wr) count_q <= count_q + 1'b1;

      if (sealed_q && in_range) begin
        fetch_inst_q  <= mem[slot];
        fetch_valid_q <= 1'b1;
      end else begin
        fetch_inst_q  <= NOP;
        fetch_valid_q <= 1'b0;
      end

      case (state_q)
        S_LOAD:  if (enc.seal) state_q <= S_DRAIN;
        S_DRAIN: if (!stg_vld_q) begin
          state_q  <= S_RUN;
          sealed_q <= 1'b1;
        end
        S_RUN:   if (enc.clear) begin
          state_q  <= S_LOAD;
          count_q  <= '0;
          sealed_q <= 1'b0;
        end
        default: state_q <= S_LOAD;
      endcase
    end
  end

  assign enc.in_ready    = ready;
  assign enc.count       = count_q;
  assign enc.full        = (count_q == (ADDR_W+1)'(DEPTH));
  assign enc.err         = err_q;
  assign enc.err_cnt     = err_cnt_q;
  assign enc.sealed      = sealed_q;
  assign enc.fetch_inst  = fetch_inst_q;
  assign enc.fetch_valid = fetch_valid_q;
endmodule

// File: tb/tb_instruction_encoder.sv
// Scoreboard bench for instruction_encoder: expected words are queued at accept
// and popped as the sealed buffer is fetched back.
module tb_instruction_encoder;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;
  localparam logic [31:0] NOP = 32'h00000013;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  instruction_encoder_if #(.ADDR_W(ADDR_W)) bus();
  instruction_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (.clk(clk), .rst_n(rst_n), .enc(bus));

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  int merr = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic logic is_legal(input logic [2:0] op, input logic [4:0] rd, input logic [12:0] imm);
    if (op == 3'd7) return 1'b0;
    if (op == 3'd6 && imm[0]) return 1'b0;
    if ((op == 3'd4 || op == 3'd5) && (imm[12] != imm[11])) return 1'b0;
`ifdef ENC_X0_CHECK_EN
    if (op <= 3'd4 && rd == 5'd0) return 1'b0;
`else
    if (rd == 5'd31 && 1'b0) return 1'b0;
`endif
    return 1'b1;
  endfunction

  function automatic logic [31:0] ref_enc(input logic [2:0] op, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [12:0] imm);
    logic [6:0] f7;
    logic [2:0] f3;
    f7 = (op == 3'd1) ? 7'h20 : 7'h00;
    f3 = (op == 3'd2) ? 3'b111 : (op == 3'd3) ? 3'b110 : 3'b000;
    case (op)
      3'd4:    return {imm[11:0], rs1, 3'b011, rd, 7'h03};
      3'd5:    return {imm[11:5], rs2, rs1, 3'b011, imm[4:0], 7'h23};
      3'd6:    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'h63};
      default: return {f7, rs2, rs1, f3, rd, 7'h33};
    endcase
  endfunction

  // Leaves in_valid high so consecutive calls stream back-to-back.
  task automatic send(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [12:0] imm);
    logic acc;
    bus.in_valid = 1'b1;
    bus.in_op = op; bus.in_rd = rd; bus.in_rs1 = rs1; bus.in_rs2 = rs2; bus.in_imm = imm;
    acc = bus.in_ready;
    step();
    if (acc) begin
      if (is_legal(op, rd, imm)) exp_q.push_back(ref_enc(op, rd, rs1, rs2, imm));
      else if (merr < 255) merr++;
    end
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic seal_wait();
    bus.seal = 1'b1;
    step();
    bus.seal = 1'b0;
    chk("drain_not_sealed", bus.sealed, 0);
    for (int i = 0; i < 8 && !bus.sealed; i++) step();
    chk("sealed", bus.sealed, 1);
  endtask

  task automatic fetch(input string tag, input logic [63:0] a, input logic [31:0] inst, input logic v);
    bus.fetch_addr = a;
    step();
    chk({tag, "_inst"}, bus.fetch_inst, inst);
    chk({tag, "_valid"}, bus.fetch_valid, v);
  endtask

  task automatic check_buffer();
    int n;
    n = exp_q.size();
    chk("count_vs_model", bus.count, n);
    for (int i = 0; i < n; i++) fetch("slot", 64'(4 * i), exp_q.pop_front(), 1'b1);
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    chk("clear_sealed", bus.sealed, 0);
    chk("clear_count", bus.count, 0);
    chk("clear_ready", bus.in_ready, 1);
    exp_q.delete();
  endtask

  initial begin
    logic [2:0]  op;
    logic [12:0] imm;
    rst_n = 1'b0;
    bus.in_valid = 0; bus.in_op = 0; bus.in_rd = 0; bus.in_rs1 = 0; bus.in_rs2 = 0; bus.in_imm = 0;
    bus.seal = 0; bus.clear = 0; bus.fetch_addr = 0;
    step(); step();
    rst_n = 1'b1;
    chk("rst_count", bus.count, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_err_cnt", bus.err_cnt, 0);
    chk("rst_sealed", bus.sealed, 0);
    chk("rst_inst", bus.fetch_inst, NOP);
    chk("rst_fvalid", bus.fetch_valid, 0);
    chk("rst_ready", bus.in_ready, 1);

    // ld x5, 8(x2)
    send(3'd4, 5'd5, 5'd2, 5'd0, 13'd8); idle();
    chk("lat_count0", bus.count, 0);
    step();
    chk("ld_count", bus.count, 1);
    seal_wait();
    fetch("ld_const", 64'd0, 32'h00813283, 1'b1);
    check_buffer();
    do_clear();

    // sd x25, 16(x2) at slot 1
    send(3'd4, 5'd5, 5'd2, 5'd0, 13'd8);
    send(3'd5, 5'd0, 5'd2, 5'd25, 13'd16); idle(); step();
    seal_wait();
    fetch("sd_const", 64'd4, 32'h01913823, 1'b1);
    check_buffer();
    do_clear();

    // beq -8 legal, beq +5 rejected
    send(3'd6, 5'd0, 5'd1, 5'd2, 13'h1FF8);
    send(3'd6, 5'd0, 5'd1, 5'd2, 13'd5); idle(); step();
    chk("beq_err", bus.err, 1);
    chk("beq_err_cnt", bus.err_cnt, merr);
    chk("beq_count", bus.count, 1);
    step();
    chk("beq_err_pulse", bus.err, 0);
    seal_wait();
    fetch("beq_const", 64'd0, 32'hFE208CE3, 1'b1);
    check_buffer();
    do_clear();

    // sub/add/and/or streamed
    send(3'd1, 5'd3, 5'd1, 5'd2, 13'd0);
    send(3'd0, 5'd4, 5'd1, 5'd2, 13'd0);
    send(3'd2, 5'd6, 5'd7, 5'd8, 13'd0);
    send(3'd3, 5'd9, 5'd10, 5'd11, 13'd0); idle();
    chk("stream_count3", bus.count, 3);
    step();
    chk("stream_count4", bus.count, 4);
    seal_wait();
    fetch("sub_const", 64'd0, 32'h402081B3, 1'b1);
    check_buffer();
    do_clear();

    // err_cnt saturation with reserved op and out-of-range ld
    for (int i = 0; i < 258; i++) send(3'd7, 5'd1, 5'd1, 5'd1, 13'd0);
    send(3'd4, 5'd1, 5'd1, 5'd1, 13'h0800); idle(); step(); step();
    chk("err_sat", bus.err_cnt, 255);
    chk("err_sat_model", bus.err_cnt, merr);
    chk("err_no_write", bus.count, 0);

    // fill to DEPTH
    for (int i = 0; i < DEPTH; i++) begin
      op = 3'($urandom_range(0, 6));
      imm = 13'($urandom);
      if (op == 3'd4 || op == 3'd5) imm[12] = imm[11];
      if (op == 3'd6) imm[0] = 1'b0;
      send(op, 5'($urandom_range(1, 31)), 5'($urandom), 5'($urandom), imm);
    end
    idle(); step();
    chk("full", bus.full, 1);
    chk("full_ready", bus.in_ready, 0);
    chk("full_count", bus.count, DEPTH);
    send(3'd0, 5'd1, 5'd1, 5'd1, 13'd0); idle(); step();
    chk("full_no_accept", bus.count, DEPTH);
    fetch("pre_seal", 64'd0, NOP, 1'b0);
    seal_wait();
    fetch("oob", 64'(4 * DEPTH), NOP, 1'b0);
    fetch("upper", 64'h1_0000_0000, NOP, 1'b0);
    fetch("lowbits", 64'(4 * (DEPTH - 1) + 3), exp_q[DEPTH-1], 1'b1);
    check_buffer();
    do_clear();

    // seal together with an accepted descriptor
    bus.seal = 1'b1;
    send(3'd0, 5'd12, 5'd13, 5'd14, 13'd0); idle();
    bus.seal = 1'b0;
    chk("seal_acc_drain", bus.sealed, 0);
    for (int i = 0; i < 8 && !bus.sealed; i++) step();
    chk("seal_acc_run", bus.sealed, 1);
    check_buffer();
    do_clear();

    // reset during DRAIN
    send(3'd0, 5'd1, 5'd2, 5'd3, 13'd0); idle();
    bus.seal = 1'b1; step(); bus.seal = 1'b0;
    rst_n = 1'b0; step(); rst_n = 1'b1;
    exp_q.delete(); merr = 0;
    chk("rst_drain_count", bus.count, 0);
    chk("rst_drain_sealed", bus.sealed, 0);
    chk("rst_drain_fvalid", bus.fetch_valid, 0);
    chk("rst_drain_ready", bus.in_ready, 1);
    chk("rst_drain_errcnt", bus.err_cnt, merr);
    send(3'd3, 5'd20, 5'd21, 5'd22, 13'd0); idle(); step();
    seal_wait();
    check_buffer();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/instruction_encoder.md
Name: instruction_encoder

Overview:
- Encodes instruction descriptors into 32-bit RV64 machine words for the subset our decode stage supports: R-type add/sub/and/or, ld, sd and beq.
- Stores the encoded words in an internal program buffer.
- Serves the buffer to instruction fetch by byte address once loading is sealed.
- Sits between the test/program loader and fetch. It is the producing end of the instruction format that decode consumes.

Parameters:
- DEPTH, 64, number of 32-bit instruction slots (power of two).
- ADDR_W, 6, log2(DEPTH); width of the slot index and of count.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  descriptor present.
- in_ready  output  1  descriptor can be accepted.
- in_op  input  3  0=add, 1=sub, 2=and, 3=or, 4=ld, 5=sd, 6=beq, 7=reserved.
- in_rd  input  5  destination register (add/sub/and/or/ld).
- in_rs1  input  5  source register 1.
- in_rs2  input  5  source register 2 (R-type/sd/beq).
- in_imm  input  13  signed immediate: byte offset for ld/sd, branch offset for beq.
- seal  input  1  pulse; end loading.
- clear  input  1  pulse; in RUN, return to LOAD and empty buffer.
- count  output  ADDR_W+1  number of slots written.
- full  output  1  count==DEPTH.
- err  output  1  one-cycle pulse per rejected descriptor.
- err_cnt  output  8  saturating count of rejected descriptors.
- sealed  output  1  high in RUN.
- fetch_addr  input  64  byte address (PC).
- fetch_inst  output  32  registered instruction word.
- fetch_valid  output  1  registered; fetch_inst came from a written slot.

Behaviour:
- Reset values: state=LOAD, count=0, stage register empty, err=0, err_cnt=0, sealed=0, fetch_inst=32'h00000013 (NOP), fetch_valid=0. Buffer contents are not cleared.
- States:
  - LOAD: accepting descriptors.
  - DRAIN: seal seen; waiting for the stage register to empty.
  - RUN: fetch serving.
- Transitions:
  - LOAD->DRAIN on seal.
  - DRAIN->RUN when the stage register is empty. Minimum one cycle in DRAIN.
  - RUN->LOAD on clear. This sets count=0 and sealed=0. clear is ignored outside RUN; seal is ignored outside LOAD.
- Pipeline:
  - Stage 1 captures a descriptor on in_valid&&in_ready.
  - Stage 2 (next edge) validates, encodes and writes slot[count], then count increments.
  - Accept-to-count latency is 2 cycles; one descriptor per cycle is sustained.
- in_ready = (state==LOAD) && (count + stage_valid < DEPTH). No accept when full, and none in DRAIN or RUN.
- seal and an accepted descriptor in the same cycle: the descriptor is still accepted and written before RUN.
- Encoding:
  - R-type: opcode 0110011, funct3 000/000/111/110 and funct7 0000000/0100000/0000000/0000000 for add/sub/and/or.
  - ld: imm[11:0], rs1, funct3 011, rd, opcode 0000011.
  - sd: imm[11:5], rs2, rs1, funct3 011, imm[4:0], opcode 0100011.
  - beq: imm[12], imm[10:5], rs2, rs1, funct3 000, imm[4:1], imm[11], opcode 1100011.
- Illegal descriptors are not written and count is unchanged; err pulses in the stage-2 cycle and err_cnt increments, saturating at 255. A descriptor is illegal if:
  - in_op==7;
  - beq with imm[0]=1;
  - ld/sd with imm[12]!=imm[11] (outside the 12-bit signed range).
- Fields unused by an op are ignored.
- Fetch, 1-cycle latency:
  - Slot index is fetch_addr[ADDR_W+1:2]; fetch_addr[1:0] is ignored.
  - If sealed and fetch_addr < 4*count: fetch_inst=slot and fetch_valid=1.
  - Otherwise fetch_inst=32'h00000013 and fetch_valid=0. This covers out-of-range addresses (including upper bits set) and all of LOAD/DRAIN.
- Reset mid-operation, in any state: in-flight stage content is discarded and all outputs return to reset values on the next edge.

Optional Feature:
- ENC_X0_CHECK_EN
- Defined: add/sub/and/or/ld with rd==0 is illegal (err pulse, not written).
- Undefined: rd==0 is encoded normally.

Test Plan:
1. ld rd=5 rs1=2 imm=8, seal, fetch_addr=0 -> fetch_inst=32'h00813283, fetch_valid=1, count=1.
2. sd rs2=25 rs1=2 imm=16 at slot 1, seal, fetch_addr=4 -> 32'h01913823.
3. beq rs1=1 rs2=2 imm=-8 (13'h1FF8) -> 32'hFE208CE3; beq imm=5 -> err pulse, err_cnt=1, count unchanged.
4. sub rd=3 rs1=1 rs2=2 streamed back-to-back with add/and/or (in_valid held) -> 32'h402081B3 at slot 0; 4 slots written in 4+1 cycles; count=4 two cycles after the last accept.
5. Fill DEPTH descriptors -> full=1, in_ready=0; seal; fetch_addr=4*DEPTH -> NOP, fetch_valid=0; fetch before seal -> NOP, fetch_valid=0.
6. seal together with an accepted descriptor -> descriptor present in RUN. rst_n=0 during DRAIN -> count=0, state LOAD, fetch_valid=0 next cycle. clear in RUN -> LOAD, count=0.
